la_dhstx: RTL and testbench



---
 rtl/la_cdc_pkg.sv | 10 +
 rtl/la_dsync.sv | 38 +++
 rtl/la_dhstx.sv | 77 +++++++
 tb/tb_la_dhstx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/la_cdc_pkg.sv
// Shared encodings for the toggle-handshake clock-domain-crossing blocks.
// The transmit and receive sides both import this package.
package la_cdc_pkg;

    typedef enum logic {
        LA_CDC_IDLE = 1'b0,
        LA_CDC_WAIT = 1'b1
    } la_cdc_state_t;

endpackage

// File: rtl/la_dsync.sv
// Single-bit level synchronizer made of a chain of flops.
// Bringing an asynchronous signal through this chain is the only safe way for it to reach logic.
module la_dsync #(
    parameter        PROP   = "DEFAULT",
    parameter int    STAGES = 2,
    parameter int    RND    = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    // A non-zero RND adds one more stage, so simulation can cover late metastability resolution.
    localparam int DEPTH = STAGES + ((RND != 0) ? 1 : 0);

    logic [DEPTH-1:0] sync_q;

    generate
        if (PROP == "DEFAULT") begin : g_generic
            // Shift the asynchronous input through the synchronizer chain.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) sync_q <= '0;
                else       sync_q <= {sync_q[DEPTH-2:0], din};
            end
        end else begin : g_tech
            // A library synchronizer cell can be substituted here for other properties.
            // Until then they use the same flop chain.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) sync_q <= '0;
                else       sync_q <= {sync_q[DEPTH-2:0], din};
            end
        end
    endgenerate

    assign dout = sync_q[DEPTH-1];

endmodule

// File: rtl/la_dhstx.sv
// Transmit side of a two-phase (toggle) handshake that carries a word into another clock domain.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no transfer open; a valid word is accepted immediately
//   WAIT  | tx_req toggled, tx_data held until the far end echoes on tx_ack
module la_dhstx
    import la_cdc_pkg::*;
#(
    parameter        PROP   = "DEFAULT",
    parameter int    DW     = 32,
    parameter int    STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          tx_req,
    output logic [DW-1:0] tx_data,
    input  logic          tx_ack,
    output logic          busy,
    output logic          err
);

    la_cdc_state_t state;
    logic          ack_s;

    la_dsync #(
        .PROP   (PROP),
        .STAGES (STAGES),
        .RND    (0)
    ) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .din   (tx_ack),
        .dout  (ack_s)
    );

    // Handshake FSM. tx_data and tx_req move on the same edge, so the far end's tx_req
    // synchronizer guarantees the data has settled before it is used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= LA_CDC_IDLE;
            tx_req  <= 1'b0;
            tx_data <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                LA_CDC_IDLE: begin
                    // An ack edge with nothing outstanding is a protocol error. It is sticky but harmless.
                    if (ack_s != tx_req) err <= 1'b1;
                    if (in_valid) begin
                        tx_data <= in_data;
                        tx_req  <= ~tx_req;
                        busy    <= 1'b1;
                        state   <= LA_CDC_WAIT;
                    end
                end
                LA_CDC_WAIT: begin
                    if (ack_s == tx_req) begin
                        busy  <= 1'b0;
                        state <= LA_CDC_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= LA_CDC_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (state == LA_CDC_IDLE) & ~reset;

endmodule

// File: tb/tb_la_dhstx.sv
// Directed bench for la_dhstx.
// A far-end model re-times tx_req, latches tx_data into a scoreboard queue and echoes the ack after a programmable latency.
module tb_la_dhstx;

    localparam int DW     = 32;
    localparam int STAGES = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          tx_req;
    logic [DW-1:0] tx_data;
    logic          tx_ack;
    logic          busy;
    logic          err;

    la_dhstx #(.PROP("DEFAULT"), .DW(DW), .STAGES(STAGES)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tx_req   (tx_req),
        .tx_data  (tx_data),
        .tx_ack   (tx_ack),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // far-end model state
    logic          fe_rst   = 1'b1;
    int            fe_lat   = 0;
    int            spur_req = 0;
    int            spur_seen;
    int            fe_dly;
    logic          fe_s1, fe_s2, fe_last;
    int            ack_cyc  = 0;
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];

    // tx_req toggle counter
    int   req_toggles = 0;
    logic req_prev    = 1'b0;

    // Far-end model: re-times tx_req on two flops and latches tx_data when a new request arrives.
    // It sets tx_ack = tx_req after fe_lat cycles and can inject a spurious ack toggle.
    always @(negedge clk) begin
        if (fe_rst) begin
            fe_s1 = 1'b0; fe_s2 = 1'b0; fe_last = 1'b0; fe_dly = -1;
            tx_ack = 1'b0; spur_seen = spur_req;
            got_q.delete();
        end else begin
            if (spur_seen != spur_req) begin
                tx_ack    = ~tx_ack;
                ack_cyc   = cyc;
                spur_seen = spur_req;
            end
            fe_s2 = fe_s1;
            fe_s1 = tx_req;
            if (fe_dly > 0) fe_dly = fe_dly - 1;
            if (fe_dly == 0) begin
                tx_ack  = fe_last;
                ack_cyc = cyc;
                fe_dly  = -1;
            end
            if (fe_s2 != fe_last && fe_dly < 0) begin
                fe_last = fe_s2;
                got_q.push_back(tx_data);
                if (fe_lat == 0) begin
                    tx_ack  = fe_last;
                    ack_cyc = cyc;
                end else begin
                    fe_dly = fe_lat;
                end
            end
        end
        if (tx_req !== req_prev) req_toggles = req_toggles + 1;
        req_prev = tx_req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic exp_req = 1'b0;

    // Call at a negedge with in_ready=1; returns at the negedge where in_ready is 1 again.
    task automatic send_word(input logic [DW-1:0] d, input bit wiggle, output int ack_to_ready);
        int n;
        bit stable;
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(d);
        exp_req  = ~exp_req;
        @(negedge clk);
        in_valid = 1'b0;
        check("req_toggle", {31'b0, tx_req}, {31'b0, exp_req});
        check("data_load", tx_data, d);
        check("busy_open", {31'b0, busy}, 32'd1);
        n = 0;
        stable = 1'b1;
        while (in_ready !== 1'b1 && n < 200) begin
            if (wiggle) in_data = $urandom;
            if (busy !== 1'b1 || tx_data !== d || tx_req !== exp_req) stable = 1'b0;
            @(negedge clk);
            n++;
        end
        check("hold_stable", {31'b0, stable}, 32'd1);
        check("ready_timeout", {31'b0, (n < 200)}, 32'd1);
        ack_to_ready = cyc - ack_cyc;
    endtask

    task automatic drain_scoreboard();
        logic [DW-1:0] g, e;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = ~g;
            check("sb_word", g, e);
        end
    endtask

    initial begin
        int d2r;
        int n;
        int tog0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_tx_req", {31'b0, tx_req}, 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        reset  = 1'b0;
        fe_rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", {31'b0, in_ready}, 32'd1);

        // single word with a 5-cycle far-end echo
        fe_lat = 5;
        send_word(32'hDEAD_BEEF, 1'b0, d2r);
        check("ack_to_ready", d2r, STAGES + 1);
        drain_scoreboard();

        // back-to-back words with zero-latency echo
        fe_lat = 0;
        tog0 = req_toggles;
        for (int i = 0; i < 8; i++) send_word(i, 1'b0, d2r);
        repeat (4) @(negedge clk);
        check("b2b_toggles", req_toggles - tog0, 32'd8);
        check("b2b_count", got_q.size(), 32'd8);
        drain_scoreboard();

        // input wiggle during WAIT
        fe_lat = 6;
        send_word(32'h0BAD_F00D, 1'b1, d2r);
        drain_scoreboard();
        check("wiggle_left", exp_q.size(), 32'd0);

        // spurious ack while IDLE
        fe_lat = 0;
        @(posedge clk);
        #1 spur_req = spur_req + 1;
        n = 0;
        while (err !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("err_delay", cyc - ack_cyc, STAGES + 1);
        repeat (5) @(negedge clk);
        check("err_sticky", {31'b0, err}, 32'd1);
        send_word(32'h1234_5678, 1'b0, d2r);
        repeat (5) @(negedge clk);
        check("post_err_cnt", got_q.size(), 32'd1);
        drain_scoreboard();
        check("post_err_ready", {31'b0, in_ready}, 32'd1);
        check("err_still", {31'b0, err}, 32'd1);

        // reset during WAIT
        fe_lat   = 20;
        in_valid = 1'b1;
        in_data  = 32'h5555_AAAA;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_busy", {31'b0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset  = 1'b1;
        fe_rst = 1'b1;
        #1;
        check("async_tx_req", {31'b0, tx_req}, 32'd0);
        check("async_busy", {31'b0, busy}, 32'd0);
        check("async_ready", {31'b0, in_ready}, 32'd0);
        check("async_err", {31'b0, err}, 32'd0);
        exp_q.delete();
        exp_req = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        fe_rst = 1'b0;
        fe_lat = 2;
        @(negedge clk);
        send_word(32'hA5A5_0F0F, 1'b0, d2r);
        repeat (5) @(negedge clk);
        check("rst_xfer_cnt", got_q.size(), 32'd1);
        drain_scoreboard();
        check("rst_xfer_err", {31'b0, err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
